// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the dual-issue pipeline datapath and its hazard controller.
// master: datapath side (drives operand/destination info, consumes controls)
// slave : hazard controller side
interface pipe_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // ID-stage source registers and valid
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rt1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rt2;
  logic             id_valid;

  // Downstream destinations
  logic [REG_W-1:0] ex_rd1;
  logic [REG_W-1:0] ex_rd2;
  logic             ex_memRd1;
  logic             ex_regWrite2;
  logic [REG_W-1:0] mem_rd1;
  logic [REG_W-1:0] wb_rd1;
  logic             mem_regWrite1;
  logic             wb_regWrite1;

  // Control events
  logic             branch_taken;
  logic             mem_busy;

  // Controls back to the pipeline
  logic             pc_we;
  logic             if_id_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_flush;
  logic             id_flush;
  logic [1:0]       fwdA1;
  logic [1:0]       fwdB1;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rt1, id_rs2, id_rt2, id_valid,
    output ex_rd1, ex_rd2, ex_memRd1, ex_regWrite2,
    output mem_rd1, wb_rd1, mem_regWrite1, wb_regWrite1,
    output branch_taken, mem_busy,
    input  pc_we, if_id_we, ex_mem_we, mem_wb_we, if_flush, id_flush,
    input  fwdA1, fwdB1, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rt1, id_rs2, id_rt2, id_valid,
    input  ex_rd1, ex_rd2, ex_memRd1, ex_regWrite2,
    input  mem_rd1, wb_rd1, mem_regWrite1, wb_regWrite1,
    input  branch_taken, mem_busy,
    output pc_we, if_id_we, ex_mem_we, mem_wb_we, if_flush, id_flush,
    output fwdA1, fwdB1, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a dual-issue in-order pipeline: load-use and slot-2
// stalls, branch flush, memory-busy freeze with state replay, slot-1 forwarding.
// Pipeline controls are combinational from the current state and ID/EX info.
// Optional feature macro: HAZ_PERF_CNT_EN enables saturating stall/flush counters.
module pipe_hazard_ctrl (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    BRFLUSH = 2'b10,
    FREEZE  = 2'b11
  } state_e;

  state_e state_q, state_d;
  state_e saved_q, saved_d;

  logic load_use_c, slot2_c, hazard_c;
  logic pc_we_c, if_id_we_c, ex_mem_we_c, mem_wb_we_c, if_flush_c, id_flush_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Hazard detection; register 0 never matches
  always_comb begin
    load_use_c = bus.id_valid && bus.ex_memRd1 && (bus.ex_rd1 != 5'd0) &&
                 ((bus.ex_rd1 == bus.id_rs1) || (bus.ex_rd1 == bus.id_rt1) ||
                  (bus.ex_rd1 == bus.id_rs2) || (bus.ex_rd1 == bus.id_rt2));
    // Slot-2 results have no forwarding path into slot-1 operands
    slot2_c    = bus.id_valid && bus.ex_regWrite2 && (bus.ex_rd2 != 5'd0) &&
                 ((bus.ex_rd2 == bus.id_rs1) || (bus.ex_rd2 == bus.id_rt1));
    hazard_c   = load_use_c || slot2_c;
  end

  // Next-state and pipeline controls: mem_busy > hazard > branch
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    pc_we_c     = 1'b1;
    if_id_we_c  = 1'b1;
    ex_mem_we_c = 1'b1;
    mem_wb_we_c = 1'b1;
    if_flush_c  = 1'b0;
    id_flush_c  = 1'b0;

    if (bus.mem_busy) begin
      pc_we_c     = 1'b0;
      if_id_we_c  = 1'b0;
      ex_mem_we_c = 1'b0;
      mem_wb_we_c = 1'b0;
      state_d     = FREEZE;
      if (state_q != FREEZE) begin
        saved_d = state_q;
      end
    end else begin
      if (hazard_c) begin
        pc_we_c    = 1'b0;
        if_id_we_c = 1'b0;
        id_flush_c = 1'b1;
        state_d    = LDSTALL;
      end else if (bus.branch_taken) begin
        if_flush_c = 1'b1;
        state_d    = BRFLUSH;
      end else begin
        state_d    = RUN;
      end
      // Leaving a freeze resumes the interrupted state
      if (state_q == FREEZE) begin
        state_d = saved_q;
        saved_d = RUN;
      end
    end
  end

  // State and saved-state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  // Slot-1 forwarding select: EX/MEM beats MEM/WB
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (bus.mem_regWrite1 && (bus.mem_rd1 != 5'd0) && (bus.mem_rd1 == bus.id_rs1)) begin
      fwd_a_c = 2'b01;
    end else if (bus.wb_regWrite1 && (bus.wb_rd1 != 5'd0) && (bus.wb_rd1 == bus.id_rs1)) begin
      fwd_a_c = 2'b10;
    end
    if (bus.mem_regWrite1 && (bus.mem_rd1 != 5'd0) && (bus.mem_rd1 == bus.id_rt1)) begin
      fwd_b_c = 2'b01;
    end else if (bus.wb_regWrite1 && (bus.wb_rd1 != 5'd0) && (bus.wb_rd1 == bus.id_rt1)) begin
      fwd_b_c = 2'b10;
    end
  end

  // Outputs forced to pass-through values while reset is held
  assign bus.pc_we     = reset ? pc_we_c     : 1'b1;
  assign bus.if_id_we  = reset ? if_id_we_c  : 1'b1;
  assign bus.ex_mem_we = reset ? ex_mem_we_c : 1'b1;
  assign bus.mem_wb_we = reset ? mem_wb_we_c : 1'b1;
  assign bus.if_flush  = reset ? if_flush_c  : 1'b0;
  assign bus.id_flush  = reset ? id_flush_c  : 1'b0;
  assign bus.fwdA1     = reset ? fwd_a_c     : 2'b00;
  assign bus.fwdB1     = reset ? fwd_b_c     : 2'b00;
  assign bus.state     = 2'(state_q);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((if_flush_c || id_flush_c) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule
